// File: rtl/vc_input_buffer_pkg.sv
// -----------------------------------------------------------------------------
// vc_input_buffer_pkg
// Shared constants and types for the per-VC router input buffer.
//   DATA_WIDTH          default flit payload width
//   VC_NUM_DEF          default number of virtual channels
//   VC_DEPTH            default slots per VC FIFO
//   VCW                 VC index width
//   HEAD_OFS / TAIL_OFS sideband bit offsets above the payload in a stored
//                       entry; an entry is {head, tail, data}
//   rd_state_e          read-side lock FSM states
// -----------------------------------------------------------------------------
package vc_input_buffer_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int VC_NUM_DEF = 4;
  localparam int VC_DEPTH   = 4;
  localparam int VCW        = 2;

  localparam int HEAD_OFS = 1;
  localparam int TAIL_OFS = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } rd_state_e;

  function automatic int entry_width(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/vc_input_buffer_vc_fifo.sv
// -----------------------------------------------------------------------------
// vc_input_buffer_vc_fifo
// Single-clock synchronous FIFO holding the entries of one virtual channel.
// The front entry is visible combinationally from the storage array.
// A push and a pop in the same cycle both take effect, including when the
// FIFO is full. A push into an empty FIFO is not bypassed to front_o.
//   clk      clock, rising edge
//   reset    synchronous active-high reset; empties the FIFO
//   push_i   write data_i at the tail (ignored when full and not popping)
//   pop_i    remove the front entry (ignored when empty)
//   data_i   entry to write
//   front_o  current front entry
//   full_o   all DEPTH slots occupied
//   empty_o  no entries stored
// -----------------------------------------------------------------------------
module vc_input_buffer_vc_fifo
  import vc_input_buffer_pkg::*;
#(
  parameter int W     = entry_width(DATA_WIDTH),
  parameter int DEPTH = VC_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] front_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full case from the empty case.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign front_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: every slot is written before it can be read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/vc_input_buffer.sv
// -----------------------------------------------------------------------------
// vc_input_buffer
// Per-VC input buffer in front of route computation. Flits from the link are
// stored in one FIFO per VC. One VC at a time is presented downstream, and a
// credit is returned upstream one cycle after every pop. Wormhole packets are
// never interleaved: a popped non-tail head locks the VC until its tail pops.
//
// Optional build macro: VC_INPUT_BUFFER_ERR_EN adds err / err_vch, a sticky
// protocol-error flag and the first offending VC.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   in_valid/in_vch         link flit valid and its VC
//   in_head/in_tail/in_data link flit sideband and payload
//   out_valid/out_ready     presented-flit handshake to route computation
//   out_vch/out_head/out_tail/out_data  presented flit
//   credit_valid/credit_vch one freed slot, registered after each pop
//   vc_empty                per-VC empty flags
//   err/err_vch             (macro only) sticky protocol error and its VC
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no VC locked; round-robin among VCs whose front is a head
// ST_LOCKED | mid-packet on lock_q; only that VC is presented
// -----------------------------------------------------------------------------
module vc_input_buffer
  import vc_input_buffer_pkg::*;
#(
  parameter int VC_NUM = VC_NUM_DEF,
  parameter int DEPTH  = VC_DEPTH,
  parameter int DW     = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [VCW-1:0]    in_vch,
  input  logic              in_head,
  input  logic              in_tail,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VCW-1:0]    out_vch,
  output logic              out_head,
  output logic              out_tail,
  output logic [DW-1:0]     out_data,
  output logic              credit_valid,
  output logic [VCW-1:0]    credit_vch,
  output logic [VC_NUM-1:0] vc_empty
`ifdef VC_INPUT_BUFFER_ERR_EN
  ,
  output logic              err,
  output logic [VCW-1:0]    err_vch
`endif
);

  localparam int EW = entry_width(DW);

  logic [EW-1:0]     entry_in_w;
  logic [EW-1:0]     front_w [VC_NUM];
  logic [EW-1:0]     sel_entry_w;
  logic [VC_NUM-1:0] push_w, pop_w, full_w, empty_w;
  logic [VC_NUM-1:0] front_head_w, elig_w;
  logic [VC_NUM-1:0] bad_q, bad_d;

  rd_state_e         state_q, state_d;
  logic [VCW-1:0]    lock_q, lock_d;
  logic [VCW-1:0]    rr_q, rr_d;
  logic [VCW-1:0]    grant_vc_w, sel_w;
  logic              grant_found_w, pop_any_w;
  logic              credit_valid_q;
  logic [VCW-1:0]    credit_vch_q;

  assign entry_in_w = {in_head, in_tail, in_data};

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    // A write to a full VC is dropped unless that VC pops on the same edge.
    assign push_w[v] = in_valid & (in_vch == VCW'(v)) & (~full_w[v] | pop_w[v]);
    assign front_head_w[v] = front_w[v][DW+HEAD_OFS];
    // Protocol-bad VCs stay out of arbitration until reset.
    assign elig_w[v] = ~empty_w[v] & front_head_w[v] & ~bad_q[v];

    vc_input_buffer_vc_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_w[v]),
      .pop_i   (pop_w[v]),
      .data_i  (entry_in_w),
      .front_o (front_w[v]),
      .full_o  (full_w[v]),
      .empty_o (empty_w[v])
    );
  end

  // Round-robin search starting at rr_q.
  always_comb begin
    int idx;
    idx           = 0;
    grant_found_w = 1'b0;
    grant_vc_w    = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      idx = (int'(rr_q) + i) % VC_NUM;
      if (!grant_found_w && elig_w[idx]) begin
        grant_found_w = 1'b1;
        grant_vc_w    = VCW'(idx);
      end
    end
  end

  assign sel_w       = (state_q == ST_LOCKED) ? lock_q : grant_vc_w;
  assign sel_entry_w = front_w[sel_w];

  assign out_valid = (state_q == ST_LOCKED) ? ~empty_w[lock_q] : grant_found_w;
  assign out_vch   = sel_w;
  assign out_head  = sel_entry_w[DW+HEAD_OFS];
  assign out_tail  = sel_entry_w[DW+TAIL_OFS];
  assign out_data  = sel_entry_w[DW-1:0];

  assign pop_any_w = out_valid & out_ready;
  assign pop_w     = pop_any_w ? (VC_NUM'(1) << sel_w) : '0;

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    bad_d   = bad_q;
    if (state_q == ST_IDLE) bad_d = bad_q | (~empty_w & ~front_head_w);
    if (pop_any_w) begin
      if (out_tail) begin
        // A head+tail flit lands here directly and never locks.
        state_d = ST_IDLE;
        rr_d    = (int'(sel_w) == VC_NUM - 1) ? '0 : sel_w + VCW'(1);
      end else if (state_q == ST_IDLE) begin
        state_d = ST_LOCKED;
        lock_d  = sel_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      lock_q         <= '0;
      rr_q           <= '0;
      bad_q          <= '0;
      credit_valid_q <= 1'b0;
      credit_vch_q   <= '0;
    end else begin
      state_q        <= state_d;
      lock_q         <= lock_d;
      rr_q           <= rr_d;
      bad_q          <= bad_d;
      credit_valid_q <= pop_any_w;
      credit_vch_q   <= sel_w;
    end
  end

  assign credit_valid = credit_valid_q;
  assign credit_vch   = credit_vch_q;
  assign vc_empty     = empty_w;

`ifdef VC_INPUT_BUFFER_ERR_EN
  logic              err_q;
  logic [VCW-1:0]    err_vch_q;
  logic [VC_NUM-1:0] new_bad_w;
  logic              wr_err_w, bad_found_w;
  logic [VCW-1:0]    bad_vc_w;

  assign new_bad_w = bad_d & ~bad_q;
  assign wr_err_w  = in_valid & full_w[in_vch] & ~pop_w[in_vch];

  always_comb begin
    bad_found_w = 1'b0;
    bad_vc_w    = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      if (!bad_found_w && new_bad_w[i]) begin
        bad_found_w = 1'b1;
        bad_vc_w    = VCW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q     <= 1'b0;
      err_vch_q <= '0;
    end else if (!err_q) begin
      if (wr_err_w) begin
        err_q     <= 1'b1;
        err_vch_q <= in_vch;
      end else if (bad_found_w) begin
        err_q     <= 1'b1;
        err_vch_q <= bad_vc_w;
      end
    end
  end

  assign err     = err_q;
  assign err_vch = err_vch_q;
`endif

endmodule

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
- Per-virtual-channel input buffer directly upstream of the route-computation stage, inside each router input port.
- Accepts flits from the link, stores them in one FIFO per VC, and picks one VC at a time.
- Presents the picked flit to route computation as data, input VC and a first-flit flag.
- Returns one credit upstream for every flit it pops.

Parameters:
- VC_NUM, 4, number of virtual channels; VC index width is 2 bits.
- DEPTH, 4, flit slots per VC FIFO; must be a power of two, 2..16.
- DW, `DATA_WIDTH, flit payload width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  flit present on link this cycle.
- in_vch  in  2  VC of incoming flit.
- in_head  in  1  incoming flit is the first flit of its packet.
- in_tail  in  1  incoming flit is the last flit (head and tail may both be 1).
- in_data  in  DW  incoming flit.
- out_valid  out  1  flit presented to route computation.
- out_ready  in  1  route computation/allocation accepts the presented flit.
- out_vch  out  2  VC of presented flit (drives ivch).
- out_head  out  1  presented flit is a head flit (drives en).
- out_tail  out  1  presented flit is a tail flit.
- out_data  out  DW  presented flit (drives idata).
- credit_valid  out  1  one slot freed this cycle.
- credit_vch  out  2  VC of freed slot.
- vc_empty  out  VC_NUM  per-VC empty flags.

Behaviour:
- Reset (reset=1 at a rising edge):
  - All FIFOs empty, pointers 0, lock cleared, round-robin pointer 0.
  - out_valid=0, credit_valid=0, vc_empty all ones.
  - A reset mid-packet discards all stored flits; no credits are emitted for them.
- Storage:
  - Each entry holds {head, tail, data}.
  - Write when in_valid=1: entry goes to FIFO in_vch at the next edge.
  - Upstream is credit-controlled, so a write to a full VC is a protocol error. It is ignored (data dropped); no pointer moves.
- Read FSM, two states:
  - IDLE: no VC locked. Round-robin over non-empty VCs whose front entry has head=1, starting at rr_ptr. A winner is presented combinationally in the same cycle.
  - LOCKED(v): only VC v is presented, so wormhole packets are never interleaved at this stage.
- Transitions:
  - In IDLE, a head pop of a non-tail flit: lock=v, go to LOCKED.
  - A pop with tail=1 in either state: go to IDLE and set rr_ptr=v+1 mod VC_NUM.
  - A head+tail single-flit packet never locks.
- Front entry without head while in IDLE is a protocol error. That VC is skipped and never presented until reset.
- Presentation:
  - out_valid=1 whenever the selected VC is non-empty.
  - out_* is driven from the FIFO front, with zero-cycle latency from FIFO state to output.
  - Pop occurs on the edge where out_valid & out_ready. out_* must hold stable while out_valid=1 and out_ready=0.
- Credits:
  - credit_valid=1 for exactly the cycle after each pop (registered); credit_vch is the popped VC.
  - At most one credit per cycle.
- Latency: a flit written at edge N can be presented after edge N (cycle N+1) if its VC is selected. Minimum write-to-pop is 1 cycle.
- Simultaneous write and pop on the same VC:
  - Both take effect; occupancy is unchanged.
  - When full, the simultaneous write is accepted because a slot frees the same edge.
  - When empty, the written flit is not bypassed; it is visible next cycle.
- Pointer wrap: log2(DEPTH)+1-bit pointers. Full when MSBs differ and the LSBs match; empty when the pointers are equal.

Optional Feature:
- Macro: VC_INPUT_BUFFER_ERR_EN.
- When defined:
  - Adds output err (1 bit) and err_vch (2 bits).
  - err becomes a sticky 1 on a write to a full VC, or on a non-head front flit in IDLE.
  - err_vch captures the first offending VC; both clear only on reset.
- When not defined: these ports and their logic are absent; error cases behave as specified above.

Decomposition:
- Shared constants belong in defines.v: DATA_WIDTH, VC_NUM, VC_DEPTH, and flit sideband bit positions (head, tail) for stored entries.
- One sub-module is natural: vc_fifo, a single synchronous FIFO with push/pop/full/empty/front, instantiated VC_NUM times.
- Arbitration and the lock FSM stay in the top module.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> out_valid=0, credit_valid=0, vc_empty=4'b1111.
- Single-flit packet: in_vch=2, head=tail=1, data=0xA5, out_ready=1 -> out_valid next cycle with out_vch=2, out_head=1, out_data=0xA5. After the pop: credit_valid=1 with credit_vch=2 one cycle later, and no lock.
- Wormhole lock:
  - Stimulus: VC0 holds a 3-flit packet; a VC1 head arrives after the VC0 head is popped.
  - Required: all 3 VC0 flits are presented before any VC1 flit, then VC1 is granted.
- Round-robin fairness: single-flit packets on VC0..VC3 with out_ready=1 throughout -> grant order 0,1,2,3. A new VC0 packet then waits until VC1..3 have been served.
- Backpressure/full: fill VC3 to DEPTH=4 with out_ready=0 -> out_data stays stable. A 5th write is dropped (err=1, err_vch=3 with the macro). Raising out_ready drains exactly 4 flits and yields 4 credits.
- Same-edge push/pop on a full VC, then assert reset mid-packet -> occupancy stays 4 across the push/pop. Reset returns all outputs to reset values and emits no credits.
